// File: rtl/oscope_capture_pkg.sv
// Shared types and default widths for the oscilloscope trigger/capture buffer.
package oscope_capture_pkg;

  localparam int unsigned ST_W       = 3;
  localparam int unsigned DEF_BUF_AW = 13;
  localparam int unsigned DEF_DW     = 16;

  typedef enum logic [ST_W-1:0] {
    StIdle     = 3'd0,
    StFill     = 3'd1,
    StWaitTrig = 3'd2,
    StPost     = 3'd3,
    StDone     = 3'd4
  } cap_state_t;

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module dpram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-address read and write returns the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/oscope_trig_capture.sv
// Single-shot triggered capture: pre-trigger history, level/edge or software trigger,
// post-fill, then a frozen buffer read back in chronological order.
module oscope_trig_capture
  import oscope_capture_pkg::*;
#(
  parameter int unsigned BUF_AW = DEF_BUF_AW,
  parameter int unsigned DW     = DEF_DW
) (
  input  logic              lb_clk,
  input  logic              lb_rst_n,
  input  logic [DW-1:0]     adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic              sw_trig,
  input  logic              trig_en,
  input  logic              trig_slope,
  input  logic [DW-1:0]     trig_level,
  input  logic [BUF_AW-1:0] pretrig,
  input  logic [BUF_AW-1:0] buf_rd_addr,
  input  logic              buf_rd_strobe,
  output logic [DW-1:0]     buf_rd_data,
  output logic              buf_rd_valid,
  output logic [ST_W-1:0]   cap_state,
  output logic              done,
  output logic [BUF_AW-1:0] trig_pos
);

  cap_state_t        state_q, state_d;
  logic [BUF_AW-1:0] wptr_q;
  logic [BUF_AW-1:0] pre_q, pre_d;
  logic [BUF_AW-1:0] fill_q, fill_d, fill_inc;
  logic [BUF_AW-1:0] post_q, post_d;
  logic [BUF_AW-1:0] trig_pos_q, trig_pos_d;
  logic              prev_valid_q, prev_valid_d;
  logic [DW-1:0]     prev_q;
  logic              capturing, we, edge_hit, trig_hit;
  logic signed [DW-1:0] cur_s, prev_s, lvl_s;
  logic              rise, fall;
  logic [BUF_AW-1:0] rd_phys, rd_addr_q;
  logic              rd_v1_q, rd_v2_q;

  assign capturing = (state_q == StFill) || (state_q == StWaitTrig) || (state_q == StPost);
  // An arm cycle restarts the capture, so it never writes.
  assign we        = adc_valid && capturing && !arm;
  assign fill_inc  = fill_q + 1'b1;

  assign cur_s    = adc_data;
  assign prev_s   = prev_q;
  assign lvl_s    = trig_level;
  assign rise     = (prev_s < lvl_s) && (cur_s >= lvl_s);
  assign fall     = (prev_s > lvl_s) && (cur_s <= lvl_s);
  assign edge_hit = trig_en && adc_valid && prev_valid_q && (trig_slope ? fall : rise);
  assign trig_hit = sw_trig || edge_hit;

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    fill_d       = fill_q;
    post_d       = post_q;
    trig_pos_d   = trig_pos_q;
    prev_valid_d = prev_valid_q;
    if (arm) begin
      pre_d        = pretrig;
      fill_d       = '0;
      prev_valid_d = 1'b0;
      state_d      = (pretrig == '0) ? StWaitTrig : StFill;
    end else begin
      if (we) prev_valid_d = 1'b1;
      unique case (state_q)
        StFill: begin
          if (adc_valid) begin
            fill_d = fill_inc;
            if (fill_inc == pre_q) state_d = StWaitTrig;
          end
        end
        StWaitTrig: begin
          if (trig_hit) begin
            trig_pos_d = adc_valid ? wptr_q : wptr_q - 1'b1;
            // Remaining post samples = depth - pre - 1, i.e. the complement of pre.
            post_d     = ~pre_q;
            state_d    = (~pre_q == '0) ? StDone : StPost;
          end
        end
        StPost: begin
          if (adc_valid) begin
            post_d = post_q - 1'b1;
            if (post_q == BUF_AW'(1)) state_d = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      pre_q        <= '0;
      fill_q       <= '0;
      post_q       <= '0;
      trig_pos_q   <= '0;
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      fill_q       <= fill_d;
      post_q       <= post_d;
      trig_pos_q   <= trig_pos_d;
      prev_valid_q <= prev_valid_d;
      if (we) begin
        wptr_q <= wptr_q + 1'b1;
        prev_q <= adc_data;
      end
    end
  end

  assign rd_phys = trig_pos_q - pre_q + buf_rd_addr;

  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      rd_addr_q <= '0;
      rd_v1_q   <= 1'b0;
      rd_v2_q   <= 1'b0;
    end else begin
      rd_v1_q <= buf_rd_strobe;
      rd_v2_q <= rd_v1_q;
      if (buf_rd_strobe) rd_addr_q <= rd_phys;
    end
  end

  dpram #(
    .AW(BUF_AW),
    .DW(DW)
  ) u_ram (
    .clk_i  (lb_clk),
    .rst_ni (lb_rst_n),
    .we_i   (we),
    .waddr_i(wptr_q),
    .wdata_i(adc_data),
    .re_i   (rd_v1_q),
    .raddr_i(rd_addr_q),
    .rdata_o(buf_rd_data)
  );

  assign buf_rd_valid = rd_v2_q;
  assign cap_state    = state_q;
  assign done         = (state_q == StDone);
  assign trig_pos     = trig_pos_q;

endmodule

// File: tb/tb_oscope_trig_capture.sv
// Bench for oscope_trig_capture: directed capture table, random captures against a
// sample-sequence reference model, re-arm and asynchronous reset sequences.
module tb_oscope_trig_capture;

  localparam int unsigned AW    = 4;
  localparam int unsigned W     = 16;
  localparam int          Depth = 16;

  logic          lb_clk = 1'b0;
  logic          lb_rst_n = 1'b0;
  logic [W-1:0]  adc_data;
  logic          adc_valid, arm, sw_trig, trig_en, trig_slope;
  logic [W-1:0]  trig_level;
  logic [AW-1:0] pretrig, buf_rd_addr, trig_pos;
  logic          buf_rd_strobe, buf_rd_valid, done;
  logic [W-1:0]  buf_rd_data;
  logic [2:0]    cap_state;

  always #5 lb_clk = ~lb_clk;

  oscope_trig_capture #(
    .BUF_AW(AW),
    .DW    (W)
  ) dut (
    .lb_clk       (lb_clk),
    .lb_rst_n     (lb_rst_n),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .arm          (arm),
    .sw_trig      (sw_trig),
    .trig_en      (trig_en),
    .trig_slope   (trig_slope),
    .trig_level   (trig_level),
    .pretrig      (pretrig),
    .buf_rd_addr  (buf_rd_addr),
    .buf_rd_strobe(buf_rd_strobe),
    .buf_rd_data  (buf_rd_data),
    .buf_rd_valid (buf_rd_valid),
    .cap_state    (cap_state),
    .done         (done),
    .trig_pos     (trig_pos)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         sw;
  } cyc_t;

  typedef struct {
    int           pre;
    bit           en;
    bit           slope;
    logic [W-1:0] level;
    int           kind;
    int           start;
    int           nvalid;
    int           sw_a;
    int           sw_b;
    int           probe_c;
    int           probe_st;
    bit           exp_done;
    logic [W-1:0] exp_rd0;
    logic [W-1:0] exp_rdtrig;
    int           budget;
  } vec_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  cyc_t         stim[$];
  logic [W-1:0] all_wr[$];
  int           obs_st[300];
  int           obs_done_c;
  int           ran;
  logic [W-1:0] got[Depth];
  vec_t         vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge lb_clk);
    #1;
  endtask

  // Reference: walk the post-arm sample sequence using the capture rules directly.
  task automatic model(input int pre, input bit en, input bit slope, input logic [W-1:0] level,
                       output bit fin, output int fin_c, output int tidx, output int nwr);
    int n, left;
    bit trig;
    logic signed [W-1:0] prev, cur, lv;
    n = 0; left = 0; trig = 0; prev = '0; lv = level;
    fin = 0; fin_c = -1; tidx = 0;
    for (int c = 0; c < stim.size() && !fin; c++) begin
      cur = stim[c].d;
      if (n < pre) begin
        if (stim[c].v) begin n++; prev = cur; end
      end else if (!trig) begin
        bit hit;
        hit = stim[c].sw || (en && stim[c].v && n > 0 &&
              (slope ? (prev > lv && cur <= lv) : (prev < lv && cur >= lv)));
        if (stim[c].v) begin n++; prev = cur; end
        if (hit) begin
          trig = 1; tidx = n - 1; left = Depth - 1 - pre;
          if (left == 0) begin fin = 1; fin_c = c; end
        end
      end else if (stim[c].v) begin
        n++; prev = cur; left--;
        if (left == 0) begin fin = 1; fin_c = c; end
      end
    end
    nwr = n;
  endtask

  task automatic read_all(input int base_g, input bit cmp);
    int idx;
    for (int t = 0; t < Depth + 2; t++) begin
      buf_rd_strobe = (t < Depth);
      buf_rd_addr   = AW'(t);
      step();
      idx = t - 1;
      check("rd_valid", 32'(buf_rd_valid), 32'(idx >= 0 && idx < Depth));
      if (idx >= 0 && idx < Depth) begin
        got[idx] = buf_rd_data;
        if (cmp && base_g + idx >= 0) check("rd_data", 32'(buf_rd_data), 32'(all_wr[base_g + idx]));
      end
    end
    buf_rd_strobe = 1'b0;
  endtask

  task automatic capture(input int pre, input bit en, input bit slope, input logic [W-1:0] level,
                         input int budget, output bit fin);
    int fin_c, tidx, nwr, base, last;
    pretrig = AW'(pre); trig_en = en; trig_slope = slope; trig_level = level;
    adc_valid = 1'b0; sw_trig = 1'b0; arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_state", 32'(cap_state), (pre == 0) ? 32'd2 : 32'd1);
    obs_done_c = -1; ran = 0;
    for (int c = 0; c < budget; c++) begin
      if (c < stim.size()) begin
        adc_valid = stim[c].v; adc_data = stim[c].d; sw_trig = stim[c].sw;
      end else begin
        adc_valid = 1'b0; sw_trig = 1'b0;
      end
      step();
      obs_st[c] = int'(cap_state);
      ran = c + 1;
      if (done) begin obs_done_c = c; break; end
    end
    adc_valid = 1'b0; sw_trig = 1'b0;
    model(pre, en, slope, level, fin, fin_c, tidx, nwr);
    check("done", 32'(done), 32'(fin));
    base = all_wr.size();
    last = fin ? fin_c : stim.size() - 1;
    for (int c = 0; c <= last; c++) if (stim[c].v) all_wr.push_back(stim[c].d);
    if (fin) begin
      check("done_cycle", 32'(obs_done_c), 32'(fin_c));
      check("trig_pos", 32'(trig_pos), 32'((base + tidx) & (Depth - 1)));
      check("done_state", 32'(cap_state), 32'd4);
      read_all(base + tidx - pre, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    cyc_t e;
    vecs[0] = '{4, 1'b1, 1'b0, 16'd100, 0, 0, 130, -1, -1, 2, 1, 1'b1, 16'd96, 16'd100, 200};
    vecs[1] = '{8, 1'b0, 1'b0, 16'd0, 0, 0, 40, 3, 10, 3, 1, 1'b1, 16'd2, 16'd10, 60};
    vecs[2] = '{0, 1'b1, 1'b1, 16'd0, 1, 20, 30, -1, -1, 0, 2, 1'b1, 16'hFFFF, 16'hFFFF, 60};
    vecs[3] = '{0, 1'b1, 1'b0, 16'd0, 1, 20, 4, -1, -1, 3, 2, 1'b0, 16'd0, 16'd0, 30};
    vecs[4] = '{0, 1'b1, 1'b0, 16'd7, 0, 0, 40, -1, -1, 0, 2, 1'b1, 16'd7, 16'd7, 60};
    vecs[5] = '{15, 1'b1, 1'b0, 16'd220, 0, 200, 40, -1, -1, 20, 4, 1'b1, 16'd205, 16'd220, 60};

    arm = 0; sw_trig = 0; adc_valid = 0; adc_data = '0; trig_en = 0; trig_slope = 0;
    trig_level = '0; pretrig = '0; buf_rd_addr = '0; buf_rd_strobe = 0;
    repeat (3) step();
    check("rst_state", 32'(cap_state), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(buf_rd_valid), 32'd0);
    check("rst_rd_data", 32'(buf_rd_data), 32'd0);
    check("rst_trig_pos", 32'(trig_pos), 32'd0);
    lb_rst_n = 1'b1;
    repeat (5) step();
    check("idle_state", 32'(cap_state), 32'd0);

    for (int i = 0; i < 6; i++) begin
      stim.delete();
      for (int c = 0; c < vecs[i].nvalid; c++) begin
        e.v  = 1'b1;
        e.sw = (c == vecs[i].sw_a) || (c == vecs[i].sw_b);
        if (vecs[i].kind == 1 && c < 4)
          e.d = (c == 0) ? 16'd5 : (c == 1) ? 16'd3 : (c == 2) ? 16'hFFFF : 16'hFFFC;
        else
          e.d = 16'(vecs[i].start + c);
        stim.push_back(e);
      end
      capture(vecs[i].pre, vecs[i].en, vecs[i].slope, vecs[i].level, vecs[i].budget, fin);
      check("tbl_done", 32'(fin), 32'(vecs[i].exp_done));
      if (vecs[i].probe_c < ran)
        check("tbl_probe_state", 32'(obs_st[vecs[i].probe_c]), 32'(vecs[i].probe_st));
      if (vecs[i].exp_done) begin
        check("tbl_rd0", 32'(got[0]), 32'(vecs[i].exp_rd0));
        check("tbl_rdtrig", 32'(got[vecs[i].pre]), 32'(vecs[i].exp_rdtrig));
      end
    end

    for (int r = 0; r < 25; r++) begin
      stim.delete();
      for (int c = 0; c < 80; c++) begin
        e.v  = ($urandom_range(3) != 0);
        e.d  = 16'(int'($urandom_range(100)) - 50);
        e.sw = ($urandom_range(63) == 0);
        stim.push_back(e);
      end
      capture(int'($urandom_range(15)), ($urandom_range(3) != 0), 1'($urandom_range(1)),
              16'(int'($urandom_range(40)) - 20), 100, fin);
    end

    // Re-arm while capturing: arm must win over the software trigger.
    pretrig = 4'd2; trig_en = 1'b0; arm = 1'b1; step(); arm = 1'b0;
    check("rearm_fill", 32'(cap_state), 32'd1);
    adc_valid = 1'b1; adc_data = 16'h0101; step(); adc_data = 16'h0102; step(); adc_valid = 1'b0;
    check("rearm_wait", 32'(cap_state), 32'd2);
    sw_trig = 1'b1; step(); sw_trig = 1'b0;
    check("rearm_post", 32'(cap_state), 32'd3);
    arm = 1'b1; step(); arm = 1'b0;
    check("arm_in_post_state", 32'(cap_state), 32'd1);
    check("arm_in_post_done", 32'(done), 32'd0);
    adc_valid = 1'b1; step(); step(); adc_valid = 1'b0;
    check("rearm_wait2", 32'(cap_state), 32'd2);
    arm = 1'b1; sw_trig = 1'b1; step(); arm = 1'b0; sw_trig = 1'b0;
    check("arm_over_sw_state", 32'(cap_state), 32'd1);
    check("arm_over_sw_done", 32'(done), 32'd0);
    adc_valid = 1'b1; step(); step(); adc_valid = 1'b0;
    check("rearm_wait3", 32'(cap_state), 32'd2);
    sw_trig = 1'b1; step(); sw_trig = 1'b0;
    check("pre_reset_post", 32'(cap_state), 32'd3);

    // Asynchronous reset between clock edges with a read in flight.
    buf_rd_addr = '0; buf_rd_strobe = 1'b1; step(); buf_rd_strobe = 1'b0;
    #2 lb_rst_n = 1'b0;
    #1;
    check("async_state", 32'(cap_state), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_rd_valid", 32'(buf_rd_valid), 32'd0);
    check("async_rd_data", 32'(buf_rd_data), 32'd0);
    check("async_trig_pos", 32'(trig_pos), 32'd0);
    #2 lb_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_reset_rd_valid", 32'(buf_rd_valid), 32'd0);
      check("post_reset_state", 32'(cap_state), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oscope_trig_capture.md
Name: oscope_trig_capture

Overview:
- Triggered single-shot capture buffer for the oscilloscope data path.
- Consumes one channel of sample-rate ADC data, already retimed into the local-bus clock domain, with a valid strobe.
- Holds a programmable pre-trigger history and freezes on trigger plus post-fill.
- Serves frozen samples to application_top's local-bus read mux in chronological order.

Parameters:
- BUF_AW, 13: buffer address width; depth = 2**BUF_AW samples.
- DW, 16: sample width, two's complement.

Ports:
- lb_clk  in  1  local-bus clock; the sole clock.
- lb_rst_n  in  1  reset, asynchronous assert, active-low.
- adc_data  in  DW  signed sample, sampled only when adc_valid=1.
- adc_valid  in  1  sample strobe, at most one per cycle.
- arm  in  1  single-cycle pulse; starts or restarts a capture.
- sw_trig  in  1  single-cycle software trigger pulse.
- trig_en  in  1  enables the level/edge trigger.
- trig_slope  in  1  0 = rising crossing, 1 = falling crossing.
- trig_level  in  DW  signed threshold.
- pretrig  in  BUF_AW  samples retained before the trigger; latched at arm.
- buf_rd_addr  in  BUF_AW  chronological read index; 0 = oldest sample.
- buf_rd_strobe  in  1  read request.
- buf_rd_data  out  DW  read data.
- buf_rd_valid  out  1  read data qualifier.
- cap_state  out  3  current FSM state encoding.
- done  out  1  capture complete; buffer frozen.
- trig_pos  out  BUF_AW  physical buffer address of the trigger sample.

Behaviour:
- Reset values: cap_state=IDLE, done=0, buf_rd_valid=0, buf_rd_data=0, trig_pos=0. Write pointer and counters reset to 0.
- FSM states: IDLE(0), FILL(1), WAIT_TRIG(2), POST(3), DONE(4).
- arm has priority over every other event in every state:
  - latch pretrig into pre_r;
  - clear the fill counter and the prev-sample-valid flag;
  - clear done;
  - go to FILL, or go directly to WAIT_TRIG when pretrig=0.
  - arm never alters the write pointer.
- Writes: in FILL, WAIT_TRIG and POST, each adc_valid writes adc_data at wptr, then wptr increments modulo 2**BUF_AW. No writes in IDLE or DONE.
- FILL:
  - count valid samples;
  - when the count reaches pre_r (on the write of sample number pre_r), go to WAIT_TRIG;
  - triggers are ignored.
- WAIT_TRIG, trigger condition, evaluated on a valid sample:
  - sw_trig=1 in any cycle (no adc_valid required); or
  - trig_en=1, a valid previous sample exists, and the crossing holds:
    - rising: prev < trig_level AND cur >= trig_level;
    - falling: prev > trig_level AND cur <= trig_level.
  - Comparisons are signed.
  - The first sample after arm cannot edge-trigger.
- On trigger:
  - trig_pos = address of the trigger sample: the current wptr if a sample is written that cycle, else wptr−1 (the last written sample); for sw_trig without adc_valid, trig_pos = wptr−1.
  - Go to POST with post_cnt = 2**BUF_AW − pre_r − 1 remaining samples; if post_cnt=0, go straight to DONE.
- POST: decrement post_cnt on each valid sample. The write that brings it to 0 moves the FSM to DONE the next cycle. done=1 in DONE.
- DONE: buffer frozen; only arm leaves DONE.
- Read mapping: phys = (trig_pos − pre_r + buf_rd_addr) mod 2**BUF_AW. Wrap-around is natural modulo arithmetic.
- Read latency: buf_rd_strobe at cycle N → buf_rd_valid=1 with data at cycle N+2 (registered address, registered RAM output). One read per cycle, fully pipelined.
- Reads outside DONE are permitted; they return live RAM contents, and buf_rd_valid still asserts.
- Simultaneous same-address read and write in POST returns old data.
- Reset mid-capture: returns to IDLE. RAM contents are not cleared. Any in-flight buf_rd_valid is dropped.

Decomposition:
- Package oscope_capture_pkg holds:
  - state enum cap_state_t (IDLE/FILL/WAIT_TRIG/POST/DONE, 3-bit);
  - localparams ST_W=3 and default widths.
- Storage uses the existing dpram sub-module: one write port, one registered read port, both on lb_clk.
- FSM, trigger compare and address arithmetic live in the top module.

Test Plan (BUF_AW=4, DW=16 unless noted):
- Level trigger, ramp 0,1,2,… every cycle, pretrig=4, trig_en=1, rising, level=100, arm at reset+5 → trig_pos holds the address of sample 100; done after 11 further samples; reads 0..15 return 96..111; each buf_rd_valid comes 2 cycles after its strobe.
- Software trigger before pretrig fill: pretrig=8, sw_trig pulsed after 3 samples → ignored, state stays FILL. sw_trig after 10 samples → trigger; buffer reads back 2..17.
- Falling edge with signed data: samples 5,3,−1,−4, level=0, slope=1 → triggers on −1, not on 3. Rising with the same data never triggers.
- Edge cases:
  - pretrig=0, level trigger on sample 7 → FSM skips FILL; read index 0 returns 7.
  - pretrig=15 → post_cnt=0, done the cycle after the trigger; read index 15 returns the trigger sample.
- Re-arm: arm asserted in POST and again together with sw_trig in WAIT_TRIG → FSM restarts FILL both times, trigger not taken, done stays 0.
- Async reset: lb_rst_n pulsed low mid-POST with no clock edge → outputs reach reset values immediately; cap_state=IDLE; pending buf_rd_valid never asserts.
